cram_arbiter: RTL and testbench

CRAM_ARBITER -- requirements
Module: cram_arbiter

---
 rtl/vce_pkg.sv | 22 ++
 rtl/cram_req_fifo.sv | 46 ++++
 rtl/cram_arbiter.sv | 112 +++++++++++
 tb/tb_cram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vce_pkg.sv
// Shared CRAM types, sizes and arbiter state encoding for the video color RAM path.
package vce_pkg;

    localparam int unsigned CRAM_AW    = 9;
    localparam int unsigned CRAM_DW    = 9;
    localparam int unsigned CRAM_DEPTH = 512;

    typedef logic [CRAM_AW-1:0] cram_addr_t;
    typedef logic [CRAM_DW-1:0] cram_data_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       we;
        cram_addr_t addr;
        cram_data_t wdata;
    } cram_req_t;

endpackage

// File: rtl/cram_req_fifo.sv
// CPU request queue: power-of-two depth, pointers carry a wrap bit to tell full from empty.
module cram_req_fifo
    import vce_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  cram_req_t push_data,
    input  logic      pop,
    output cram_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    cram_req_t       mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            do_pop;
    logic            do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop && !empty;
    // A full queue still takes a new entry when the head leaves in the same clock.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cram_arbiter.sv
// Single-port CRAM arbiter: pixel fetches always win, queued CPU accesses fill the gaps.
// Optional CRAM_CLEAR_EN: zero the whole CRAM after reset before entering RUN.
module cram_arbiter
    import vce_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       pix_req,
    input  cram_addr_t pix_addr,
    output cram_data_t pix_data,
    output logic       pix_valid,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  cram_addr_t cpu_addr,
    input  cram_data_t cpu_wdata,
    output logic       cpu_ready,
    output cram_data_t cpu_rdata,
    output logic       cpu_rvalid,
    output cram_addr_t ram_addr,
    output logic       ram_we,
    output cram_data_t ram_wdata,
    input  cram_data_t ram_rdata
);

`ifdef CRAM_CLEAR_EN
    localparam arb_state_t RESET_STATE = CLEAR;
`else
    localparam arb_state_t RESET_STATE = RUN;
`endif

    arb_state_t state;
    cram_addr_t clr_addr;
    cram_addr_t addr_q;
    cram_data_t wdata_q;
    logic       pix_p1;
    logic       rd_p1;
    logic       pix_issue;
    logic       cpu_issue;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    cram_req_t  fifo_head;
    cram_req_t  fifo_in;

    assign cpu_ready = (state == RUN) && !fifo_full;
    assign fifo_push = cpu_req && cpu_ready;
    assign fifo_in   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};

    cram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clock),
        .rst_n     (reset_N),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (cpu_issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // RAM port mux; idle clocks replay the last address with writes disabled.
    always_comb begin
        pix_issue = 1'b0;
        cpu_issue = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_we    = 1'b0;
        if (state == CLEAR) begin
            ram_addr  = clr_addr;
            ram_wdata = '0;
            ram_we    = reset_N;
        end else if (pix_req) begin
            pix_issue = 1'b1;
            ram_addr  = pix_addr;
        end else if (!fifo_empty) begin
            cpu_issue = 1'b1;
            ram_addr  = fifo_head.addr;
            ram_wdata = fifo_head.wdata;
            ram_we    = fifo_head.we;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state      <= RESET_STATE;
            clr_addr   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pix_p1     <= 1'b0;
            rd_p1      <= 1'b0;
            pix_valid  <= 1'b0;
            cpu_rvalid <= 1'b0;
            pix_data   <= '0;
            cpu_rdata  <= '0;
        end else begin
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            pix_p1     <= pix_issue;
            rd_p1      <= cpu_issue && !fifo_head.we;
            pix_valid  <= pix_p1;
            cpu_rvalid <= rd_p1;
            if (pix_p1) pix_data  <= ram_rdata;
            if (rd_p1)  cpu_rdata <= ram_rdata;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + CRAM_AW'(1);
                if (clr_addr == CRAM_AW'(CRAM_DEPTH - 1)) state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_cram_arbiter.sv
// Scoreboard bench for cram_arbiter with a behavioural single-port CRAM (1-clock read latency).
`timescale 1ns/1ps
module tb_cram_arbiter;
    import vce_pkg::*;

    typedef struct {
        cram_data_t data;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_N = 1'b0;
    logic       pix_req = 1'b0;
    cram_addr_t pix_addr = '0;
    cram_data_t pix_data;
    logic       pix_valid;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    cram_addr_t cpu_addr = '0;
    cram_data_t cpu_wdata = '0;
    logic       cpu_ready;
    cram_data_t cpu_rdata;
    logic       cpu_rvalid;
    cram_addr_t ram_addr;
    logic       ram_we;
    cram_data_t ram_wdata;
    cram_data_t ram_rdata = '0;

    cram_data_t mem [CRAM_DEPTH];
    exp_t       pix_q [$];
    exp_t       cpu_q [$];
    exp_t       me;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    cram_arbiter #(.FIFO_DEPTH(2)) dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .pix_req    (pix_req),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < int'(CRAM_DEPTH); i++) mem[i] = 9'(i) ^ 9'h155;
    end

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic cram_data_t init_val(input cram_addr_t a);
`ifdef CRAM_CLEAR_EN
        return 9'h000;
`else
        return a ^ 9'h155;
`endif
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation in data and cycle.
    always @(negedge clock) begin
        if (reset_N) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) check("pix_unexpected_strobe", 1, 0);
                else begin
                    me = pix_q.pop_front();
                    check("pix_data", int'(pix_data), int'(me.data));
                    check("pix_valid_time", cyc, me.cyc);
                end
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", 1, 0);
                else begin
                    me = cpu_q.pop_front();
                    check("cpu_rdata", int'(cpu_rdata), int'(me.data));
                    check("cpu_rvalid_time", cyc, me.cyc);
                end
            end
            if (pix_req) begin
                check("pix_ram_addr", int'(ram_addr), int'(pix_addr));
                check("pix_ram_we", int'(ram_we), 0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pix_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic pix(input cram_addr_t a, input cram_data_t d);
        pix_req  = 1'b1;
        pix_addr = a;
        pix_q.push_back('{d, cyc + 2});
    endtask

    task automatic cpu_w(input cram_addr_t a, input cram_data_t d);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic cpu_r(input cram_addr_t a, input cram_data_t d, input logic expect_it);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        if (expect_it) cpu_q.push_back('{d, cyc + 3});
    endtask

`ifdef CRAM_CLEAR_EN
    task automatic clear_check();
        for (int j = 0; j < int'(CRAM_DEPTH); j++) begin
            @(negedge clock);
            check("clr_we", int'(ram_we), 1);
            check("clr_addr", int'(ram_addr), j);
            check("clr_ready", int'(cpu_ready), 0);
        end
        @(negedge clock);
        check("clr_done_ready", int'(cpu_ready), 1);
        check("clr_done_we", int'(ram_we), 0);
        step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int rv_cnt;
        logic [7:0] exp_ready;
        w = 0;
        rv_cnt = 0;
        exp_ready = 8'b0001_0110;

        // Reset values
        repeat (3) step();
        @(negedge clock);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_cpu_rvalid", int'(cpu_rvalid), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_cpu_rdata", int'(cpu_rdata), 0);
`ifdef CRAM_CLEAR_EN
        check("rst_cpu_ready", int'(cpu_ready), 0);
`else
        check("rst_cpu_ready", int'(cpu_ready), 1);
`endif
        step();
        reset_N = 1'b1;
`ifdef CRAM_CLEAR_EN
        clear_check();
`endif

        // CPU write then pixel fetch of the same entry
        cpu_w(9'h010, 9'h1C7);
        step();
        idle();
        step();
        pix(9'h010, 9'h1C7);
        step();
        idle();
        repeat (4) step();
        @(negedge clock);
        check("pix_data_hold", int'(pix_data), 9'h1C7);
        check("pix_valid_low", int'(pix_valid), 0);

        // Write followed immediately by read of the same address
        step();
        cpu_w(9'h1FF, 9'h0AA);
        step();
        cpu_r(9'h1FF, 9'h0AA, 1'b1);
        step();
        idle();
        repeat (4) step();
        @(negedge clock);
        check("cpu_rdata_hold", int'(cpu_rdata), 9'h0AA);
        check("cpu_rvalid_low", int'(cpu_rvalid), 0);

        // Pixel and CPU in the same clock on an empty queue
        step();
        pix(9'h005, init_val(9'h005));
        cpu_w(9'h020, 9'h055);
        step();
        idle();
        @(negedge clock);
        check("defer_ram_we", int'(ram_we), 1);
        check("defer_ram_addr", int'(ram_addr), 9'h020);
        check("defer_ram_wdata", int'(ram_wdata), 9'h055);
        repeat (4) step();

        // Pixel every 2nd clock with 3 back-to-back CPU writes
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) pix(9'(9'h080 + i), init_val(9'(9'h080 + i)));
            if (i >= 1 && w < 3) cpu_w(9'(9'h040 + w), 9'(9'h100 + w));
            @(negedge clock);
            if (i >= 1 && i <= 4) check("burst_ready", int'(cpu_ready), int'(exp_ready[i]));
            check("burst_ram_we", int'(ram_we), (i == 3 || i == 5 || i == 7) ? 1 : 0);
            if (i == 3 || i == 5 || i == 7)
                check("burst_ram_addr", int'(ram_addr), 9'h040 + (i - 3) / 2);
            if (cpu_req && cpu_ready) w++;
            step();
        end
        idle();
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            pix(9'(9'h040 + k), 9'(9'h100 + k));
            step();
        end
        idle();
        repeat (4) step();

        // Plain CPU read of an untouched address
        cpu_r(9'h123, init_val(9'h123), 1'b1);
        step();
        idle();
        repeat (4) step();

        // Reset one clock after a CPU read issues
        cpu_r(9'h030, 9'h000, 1'b0);
        step();
        idle();
        step();
        reset_N = 1'b0;
        repeat (2) step();
        reset_N = 1'b1;
`ifdef CRAM_CLEAR_EN
        clear_check();
`endif
        repeat (6) begin
            @(negedge clock);
            if (cpu_rvalid) rv_cnt++;
        end
        check("post_reset_rvalid_count", rv_cnt, 0);
        check("post_reset_ready", int'(cpu_ready), 1);

        step();
        check("pix_queue_drained", pix_q.size(), 0);
        check("cpu_queue_drained", cpu_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
